// File: rtl/score_disp_pkg.sv
// Shared encodings for the score display: game status, converter FSM states
// and active-low 7-segment glyphs (bit 0 = segment a ... bit 6 = segment g).
package score_disp_pkg;

    typedef enum logic [1:0] {
        ST_RESTART = 2'b00,
        ST_START   = 2'b01,
        ST_PLAY    = 2'b10,
        ST_DIE     = 2'b11
    } game_status_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        COMMIT = 2'b10
    } conv_state_e;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_P     = 7'h0C;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // BCD nibble to glyph; non-decimal codes render blank
    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble, one bit
// per cycle). done is high during the COMMIT cycle while the BCD outputs
// hold the finished result, so the parent can capture it on that edge.
module bin2bcd_seq
    import score_disp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] value,
    output logic       busy,
    output logic       done,
    output logic [1:0] hund,
    output logic [3:0] tens,
    output logic [3:0] units
);

    conv_state_e state;
    logic [7:0]  sh;
    logic [2:0]  cnt;
    logic [3:0]  tens_adj, units_adj;

    assign done = (state == COMMIT);

    // Add-3 correction applied before each shift; hundreds never needs it
    always_comb begin
        tens_adj  = (tens  >= 4'd5) ? tens  + 4'd3 : tens;
        units_adj = (units >= 4'd5) ? units + 4'd3 : units;
    end

    // IDLE -> SHIFT x8 -> COMMIT; start is ignored unless idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            sh    <= '0;
            cnt   <= '0;
            hund  <= '0;
            tens  <= '0;
            units <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sh    <= value;
                        hund  <= '0;
                        tens  <= '0;
                        units <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    {hund, tens, units, sh} <= {hund[0], tens_adj, units_adj, sh, 1'b0};
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7)
                        state <= COMMIT;
                end
                COMMIT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/score_seg_display.sv
// Four-digit multiplexed 7-segment display: three BCD score digits plus a
// game-status glyph on digit 3, blinking while the game is in DIE.
// Optional macro SCORE_LZB_EN enables leading-zero blanking of the score.
module score_seg_display
    import score_disp_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int SCAN_HZ     = 1000,
    parameter int BLINK_TICKS = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] score,
    input  logic [1:0] game_status,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       busy
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW  = $clog2(BLINK_TICKS + 1);

    game_status_e gs;
    logic [7:0]   last_score;
    logic         conv_start, conv_done;
    logic [1:0]   bcd_h, disp_h;
    logic [3:0]   bcd_t, bcd_u, disp_t, disp_u;
    logic [PW-1:0] presc;
    logic [1:0]   dig;
    logic         tick;
    logic [BW-1:0] blink_cnt;
    logic         blink_on;
    logic [6:0]   glyph;

    assign gs         = game_status_e'(game_status);
    assign tick       = (presc == PW'(DIV - 1));
    // busy low means the converter is idle and can take a new value
    assign conv_start = (score != last_score) && !busy;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .value (score),
        .busy  (busy),
        .done  (conv_done),
        .hund  (bcd_h),
        .tens  (bcd_t),
        .units (bcd_u)
    );

    // Track the value handed to the converter; capture results on COMMIT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_score <= '0;
            disp_h     <= '0;
            disp_t     <= '0;
            disp_u     <= '0;
        end else begin
            if (conv_start)
                last_score <= score;
            if (conv_done) begin
                disp_h <= bcd_h;
                disp_t <= bcd_t;
                disp_u <= bcd_u;
            end
        end
    end

    // Scan prescaler and digit index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
            dig   <= '0;
        end else if (tick) begin
            presc <= '0;
            dig   <= dig + 2'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Blink phase counts digit ticks in DIE; any other status forces "on"
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (gs != ST_DIE) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (tick) begin
            if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Glyph for the digit currently being scanned
    always_comb begin
        glyph = SEG_BLANK;
        case (dig)
            2'd0: glyph = seg_digit(disp_u);
`ifdef SCORE_LZB_EN
            2'd1: glyph = (disp_h == 2'd0 && disp_t == 4'd0) ? SEG_BLANK : seg_digit(disp_t);
            2'd2: glyph = (disp_h == 2'd0) ? SEG_BLANK : seg_digit({2'b00, disp_h});
`else
            2'd1: glyph = seg_digit(disp_t);
            2'd2: glyph = seg_digit({2'b00, disp_h});
`endif
            2'd3: begin
                case (gs)
                    ST_RESTART: glyph = SEG_DASH;
                    ST_START:   glyph = SEG_BLANK;
                    ST_PLAY:    glyph = SEG_P;
                    ST_DIE:     glyph = SEG_D;
                    default:    glyph = SEG_BLANK;
                endcase
            end
            default: glyph = SEG_BLANK;
        endcase
        if (gs == ST_DIE && !blink_on)
            glyph = SEG_BLANK;
    end

    // seg and an registered together so the enable and pattern never skew
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg <= SEG_BLANK;
            an  <= 4'hF;
        end else begin
            seg <= glyph;
            an  <= ~(4'b0001 << dig);
        end
    end

endmodule

// File: tb/tb_score_seg_display.sv
// Directed testbench for score_seg_display (small scan divider, BLINK_TICKS=4).
module tb_score_seg_display;

    localparam logic [6:0] G0    = 7'h40;
    localparam logic [6:0] G2    = 7'h24;
    localparam logic [6:0] G5    = 7'h12;
    localparam logic [6:0] G7    = 7'h78;
    localparam logic [6:0] GP    = 7'h0C;
    localparam logic [6:0] GDASH = 7'h3F;
    localparam logic [6:0] GBL   = 7'h7F;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] score = 8'd0;
    logic [1:0] game_status = 2'b10;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;
    logic [9:0] disp;

    int n_tests = 0;
    int n_fail  = 0;

    score_seg_display #(.CLK_HZ(4), .SCAN_HZ(1), .BLINK_TICKS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .score       (score),
        .game_status (game_status),
        .seg         (seg),
        .an          (an),
        .busy        (busy)
    );

    assign disp = {dut.disp_h, dut.disp_t, dut.disp_u};

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_an(input logic [3:0] target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            if (an === target) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(); step();
        n_tests++;
        if (seg !== GBL || an !== 4'hF || busy !== 1'b0 || disp !== 10'd0) begin
            n_fail++;
            $display("FAIL reset: seg=%h an=%b busy=%b disp=%h, want 7f 1111 0 000", seg, an, busy, disp);
        end
    endtask

    task automatic test_scan();
        logic [3:0] ean;
        logic [6:0] eseg;
        int idx;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            idx = (k - 1) / 4;
            ean = ~(4'b0001 << idx);
`ifdef SCORE_LZB_EN
            eseg = (idx == 0) ? G0 : (idx == 3) ? GP : GBL;
`else
            eseg = (idx == 3) ? GP : G0;
`endif
            n_tests++;
            if (an !== ean || seg !== eseg) begin
                n_fail++;
                $display("FAIL scan k=%0d: an=%b seg=%h, want an=%b seg=%h", k, an, seg, ean, eseg);
            end
        end
    endtask

    task automatic test_conv_255();
        bit ok;
        score = 8'd255;
        for (int k = 0; k < 9; k++) begin
            step();
            n_tests++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL conv255 busy k=%0d: got %b want 1", k, busy);
            end
        end
        n_tests++;
        if (disp !== 10'd0) begin
            n_fail++;
            $display("FAIL conv255 early commit: disp=%h want 000", disp);
        end
        step();
        n_tests++;
        if (busy !== 1'b0 || disp !== {2'd2, 4'd5, 4'd5}) begin
            n_fail++;
            $display("FAIL conv255 commit: busy=%b disp=%h want 0 255", busy, disp);
        end
        wait_an(4'b1011, ok);
        n_tests++;
        if (!ok || seg !== G2) begin
            n_fail++;
            $display("FAIL conv255 hundreds glyph: ok=%0d seg=%h want %h", ok, seg, G2);
        end
        wait_an(4'b1110, ok);
        n_tests++;
        if (!ok || seg !== G5) begin
            n_fail++;
            $display("FAIL conv255 units glyph: ok=%0d seg=%h want %h", ok, seg, G5);
        end
    endtask

    task automatic test_back_to_back();
        int at37 = -1;
        int at38 = -1;
        int bad = 0;
        score = 8'd37;
        step(); step(); step();
        score = 8'd38;
        for (int e = 3; e <= 30; e++) begin
            step();
            if (disp === {2'd0, 4'd3, 4'd7} && at37 < 0) at37 = e;
            if (disp === {2'd0, 4'd3, 4'd8} && at38 < 0) at38 = e;
            if (disp !== {2'd2, 4'd5, 4'd5} && disp !== {2'd0, 4'd3, 4'd7} &&
                disp !== {2'd0, 4'd3, 4'd8}) bad++;
            if (e == 10) begin
                n_tests++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b restart busy: got %b want 1", busy);
                end
            end
        end
        n_tests++;
        if (at37 != 9 || at38 != 19 || bad != 0) begin
            n_fail++;
            $display("FAIL b2b: 37 at %0d, 38 at %0d, bad=%0d; want 9, 19, 0", at37, at38, bad);
        end
    endtask

    task automatic test_digits_007();
        bit ok;
        logic [6:0] elead;
`ifdef SCORE_LZB_EN
        elead = GBL;
`else
        elead = G0;
`endif
        score = 8'd7;
        repeat (12) step();
        wait_an(4'b1101, ok);
        n_tests++;
        if (!ok || seg !== elead) begin
            n_fail++;
            $display("FAIL 007 tens: ok=%0d seg=%h want %h", ok, seg, elead);
        end
        wait_an(4'b1011, ok);
        n_tests++;
        if (!ok || seg !== elead) begin
            n_fail++;
            $display("FAIL 007 hundreds: ok=%0d seg=%h want %h", ok, seg, elead);
        end
        wait_an(4'b1110, ok);
        n_tests++;
        if (!ok || seg !== G7) begin
            n_fail++;
            $display("FAIL 007 units: ok=%0d seg=%h want %h", ok, seg, G7);
        end
    endtask

    task automatic test_blink();
        logic [3:0] prev;
        bit ok;
        bit eblank;
        score = 8'd123;
        repeat (12) step();
        prev = an;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            step();
            if (an !== prev) ok = 1'b1;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL blink align: an stuck at %b", an);
        end
        game_status = 2'b11;
        for (int k = 1; k <= 56; k++) begin
            step();
            eblank = ((k / 16) % 2) == 1;
            n_tests++;
            if ((seg === GBL) !== eblank) begin
                n_fail++;
                $display("FAIL blink k=%0d: seg=%h want blank=%0d", k, seg, eblank);
            end
        end
        game_status = 2'b00;
        step();
        n_tests++;
        if (seg === GBL || dut.blink_on !== 1'b1) begin
            n_fail++;
            $display("FAIL blink exit: seg=%h blink_on=%b want visible 1", seg, dut.blink_on);
        end
        wait_an(4'b0111, ok);
        n_tests++;
        if (!ok || seg !== GDASH) begin
            n_fail++;
            $display("FAIL restart glyph: ok=%0d seg=%h want %h", ok, seg, GDASH);
        end
    endtask

    task automatic test_reset_abort();
        game_status = 2'b10;
        score = 8'd200;
        step(); step(); step(); step();
        rst = 1'b0;
        #1;
        n_tests++;
        if (seg !== GBL || an !== 4'hF || busy !== 1'b0 || disp !== 10'd0) begin
            n_fail++;
            $display("FAIL abort reset: seg=%h an=%b busy=%b disp=%h", seg, an, busy, disp);
        end
        step();
        @(negedge clk);
        rst = 1'b1;
        step();
        n_tests++;
        if (busy !== 1'b1 || an !== 4'b1110) begin
            n_fail++;
            $display("FAIL abort restart: busy=%b an=%b want 1 1110", busy, an);
        end
        repeat (8) step();
        n_tests++;
        if (disp !== 10'd0) begin
            n_fail++;
            $display("FAIL abort partial: disp=%h want 000", disp);
        end
        step();
        n_tests++;
        if (disp !== {2'd2, 4'd0, 4'd0} || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort final: disp=%h busy=%b want 200 0", disp, busy);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_conv_255();
        test_back_to_back();
        test_digits_007();
        test_blink();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/score_seg_display.md
SCORE_SEG_DISPLAY -- requirements
Module: score_seg_display

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 Parameter SCAN_HZ, default 1000, per-digit scan rate in Hz; digit tick period = CLK_HZ/SCAN_HZ cycles.
REQ-003 Parameter BLINK_TICKS, default 128, digit ticks per blink half-period while in DIE status.
REQ-004 clk  input  1  single system clock; all logic in this one domain.
REQ-005 rst  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-006 score  input  8  binary game score, 0..255, from the apple generator.
REQ-007 game_status  input  2  game state from the status controller.
REQ-008 seg  output  7  segments a..g, active-low (0 = lit).
REQ-009 an  output  4  digit enables, active-low one-hot; an[0] = units digit.
REQ-010 busy  output  1  high while a BCD conversion is in progress.

Function
REQ-011 Game status encodings SHALL be RESTART=2'b00, START=2'b01, PLAY=2'b10, DIE=2'b11.
REQ-012 Converter FSM states SHALL be IDLE, SHIFT, COMMIT.
REQ-013 IDLE: when score != last_score, latch score into last_score and the shift register, clear BCD scratch, go to SHIFT; busy goes high the next cycle.
REQ-014 SHIFT: exactly 8 cycles of double-dabble (add 3 to any BCD nibble >= 5, then shift left 1); then go to COMMIT.
REQ-015 COMMIT: copy hundreds/tens/units scratch into display registers in one cycle, return to IDLE, busy low.
REQ-016 Latency: score change sampled at cycle N is shown in display registers at end of cycle N+10.
REQ-017 Score changes while busy SHALL NOT disturb the running conversion; IDLE detects the difference on its first cycle and restarts, so the final displayed value always equals the last stable score.
REQ-018 Hundreds digit width 2 bits (max 2), tens and units 4 bits; 255 SHALL display 2-5-5.
REQ-019 Scan prescaler counts 0..CLK_HZ/SCAN_HZ-1; on wrap, digit index advances 0,1,2,3,0 (wrap from 3 to 0).
REQ-020 Exactly one an bit low at any time after reset; seg updated in the same cycle as an (no ghosting skew).
REQ-021 Digit 3 shows status glyph: RESTART '-', START blank, PLAY 'P', DIE 'd'.
REQ-022 In DIE, a blink counter counts digit ticks; phase toggles every BLINK_TICKS ticks; in off phase all four digits blank (seg=7'h7F) while an keeps scanning.
REQ-023 Leaving DIE clears blink counter and phase to "on" in the same cycle.

Reset
REQ-024 While rst=0: seg=7'h7F, an=4'hF, busy=0, FSM=IDLE, last_score=0, display and scratch registers=0, prescaler=0, digit index=0, blink=on.
REQ-025 Reset asserted mid-conversion SHALL abort it; no partial value is committed.
REQ-026 First cycle after release: an=4'b1110, units digit '0' shown.

Configuration
REQ-027 Macro SCORE_LZB_EN: when defined, hundreds digit blanked if zero, tens blanked if hundreds and tens both zero; units never blanked.
REQ-028 Without SCORE_LZB_EN, all three score digits always show numerals (score 7 shows 0-0-7).

Structure
REQ-029 Package score_disp_pkg SHALL hold game status encodings, FSM state typedef, and 7-segment glyph constants (0-9, '-', 'P', 'd', blank).
REQ-030 Converter FSM SHALL be sub-module bin2bcd_seq (start/value in, busy/done/BCD out); scan, glyph and blink logic stay in the top.

Verification
REQ-031 Reset release, score=0, PLAY -> an cycles 1110,1101,1011,0111; digits 0,blank,blank,'P' with SCORE_LZB_EN; 0,0,0,'P' without.
REQ-032 score 0->255 at cycle N -> busy high N+1..N+9, display registers 2/5/5 at N+10.
REQ-033 score 37 then 38 three cycles later -> first conversion completes to 037, second starts immediately after, final display 038, never an intermediate corrupted value.
REQ-034 game_status=DIE, BLINK_TICKS=4 -> seg=7'h7F for 4 digit ticks, glyphs for next 4, repeating; switch to RESTART -> digits visible immediately, digit 3 shows '-'.
REQ-035 rst pulsed low at 4th SHIFT cycle of score 200 -> outputs reset values; after release, conversion of current score 200 runs and shows 2-0-0.
